// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - registered FIFO of {pc, instr} pairs between fetch and decode
// Storage is not reset: entries are only visible while count is non-zero.

module instr_fetch_buffer #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [31:0]              pc_in,
    input  logic [31:0]              instr_in,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [31:0]              pc_out,
    output logic [31:0]              instr_out,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            PW         = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          push;
    logic          pop;

    // No pass-through when full: a same-cycle pop does not open a slot for a push.
    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= pc_in;
            instr_mem[wr_ptr] <= instr_in;
        end
    end

    assign pc_out    = out_valid ? pc_mem[rd_ptr]    : 32'h0;
    assign instr_out = out_valid ? instr_mem[rd_ptr] : NOP_INSTR;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb/tb_instr_fetch_buffer.sv - randomized and directed bench for instr_fetch_buffer

module tb_instr_fetch_buffer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        out_ready;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    logic [63:0] mq[$];

    instr_fetch_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .pc_in     (pc_in),
        .instr_in  (instr_in),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .pc_out    (pc_out),
        .instr_out (instr_out),
        .out_ready (out_ready),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        #20;
        forever #5 clk = ~clk;
    end

    // One clock edge; the reference queue follows the fifo rules from the pre-edge inputs.
    task automatic tick();
        bit fl, do_push, do_pop;
        logic [63:0] pair;
        fl      = flush;
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = out_ready && (mq.size() > 0);
        pair    = {pc_in, instr_in};
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(pair);
        end
        #1;
    endtask

    task automatic present(input logic [31:0] pc);
        in_valid = 1'b1;
        pc_in    = pc;
        instr_in = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        pc_in = '0; instr_in = '0;
        #5 rst = 1'b1;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (instr_out !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instr_out, NOP); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
        #9 rst = 1'b0;
        #1;
        total++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL post_reset got cnt=%0d ov=%b ir=%b exp 0/0/1", count, out_valid, in_ready); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            present(32'(i * 4));
            tick();
            total++; if (out_valid !== 1'b1 || pc_out !== 32'(i * 4) || instr_out !== mq[0][31:0])
                begin bad++; $display("FAIL stream_head%0d got ov=%b pc=%h ins=%h exp 1/%h/%h", i, out_valid, pc_out, instr_out, 32'(i * 4), mq[0][31:0]); end
            total++; if (count !== 3'd1) begin bad++; $display("FAIL stream_count%0d got=%0d exp=1", i, count); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0 || instr_out !== NOP)
            begin bad++; $display("FAIL stream_drain got ov=%b ins=%h exp 0/%h", out_valid, instr_out, NOP); end
    endtask

    task automatic test_fill_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            present(32'(i * 4));
            tick();
        end
        total++; if (count !== 3'd4 || in_ready !== 1'b0)
            begin bad++; $display("FAIL fill_full got cnt=%0d ir=%b exp 4/0", count, in_ready); end
        present(32'h10);
        tick();
        total++; if (count !== 3'd4 || pc_out !== 32'h0)
            begin bad++; $display("FAIL fill_refused got cnt=%0d pc=%h exp 4/0", count, pc_out); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (pc_out !== 32'(i * 4) || instr_out !== mq[0][31:0])
                begin bad++; $display("FAIL fill_order%0d got pc=%h exp=%h", i, pc_out, 32'(i * 4)); end
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fill_empty got ov=%b exp=0", out_valid); end
        present(32'h10);
        tick();
        in_valid = 1'b0;
        total++; if (pc_out !== 32'h10 || count !== 3'd1)
            begin bad++; $display("FAIL fill_represent got pc=%h cnt=%0d exp 10/1", pc_out, count); end
        tick();
    endtask

    task automatic test_full_simultaneous();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            present(32'h40 + 32'(i * 4));
            tick();
        end
        present(32'h50);
        out_ready = 1'b1;
        tick();
        total++; if (count !== 3'd3 || in_ready !== 1'b1 || pc_out !== 32'h44)
            begin bad++; $display("FAIL full_simul got cnt=%0d ir=%b pc=%h exp 3/1/44", count, in_ready, pc_out); end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL full_drain got cnt=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            present(32'h80 + 32'(i * 4));
            tick();
        end
        present(32'h90);
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (count !== 3'd0 || out_valid !== 1'b0 || instr_out !== NOP || pc_out !== 32'h0)
            begin bad++; $display("FAIL flush_clear got cnt=%0d ov=%b ins=%h pc=%h exp 0/0/%h/0", count, out_valid, instr_out, pc_out, NOP); end
        out_ready = 1'b0;
        present(32'h100);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || pc_out !== 32'h100 || instr_out !== mq[0][31:0])
            begin bad++; $display("FAIL flush_head got ov=%b pc=%h exp 1/100", out_valid, pc_out); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        int pushed = 0;
        int popped = 0;
        int guard  = 0;
        while (popped < 10 && guard < 60) begin
            guard++;
            if (pushed < 10) present(32'h200 + 32'(pushed * 4));
            else in_valid = 1'b0;
            out_ready = (mq.size() >= 2) || (pushed >= 10);
            if (out_valid && out_ready) begin
                total++; if (pc_out !== 32'h200 + 32'(popped * 4) || instr_out !== mq[0][31:0])
                    begin bad++; $display("FAIL wrap_order%0d got pc=%h exp=%h", popped, pc_out, 32'h200 + 32'(popped * 4)); end
                popped++;
            end
            if (in_valid && in_ready) pushed++;
            tick();
        end
        in_valid = 1'b0;
        total++; if (popped != 10 || count !== 3'd0)
            begin bad++; $display("FAIL wrap_done got popped=%0d cnt=%0d exp 10/0", popped, count); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            present(32'h300 + 32'(i * 4));
            tick();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        mq.delete();
        total++; if (count !== 3'd0 || out_valid !== 1'b0 || pc_out !== 32'h0)
            begin bad++; $display("FAIL midrst_clear got cnt=%0d ov=%b pc=%h exp 0/0/0", count, out_valid, pc_out); end
        #2 rst = 1'b0;
        present(32'h400);
        tick();
        in_valid = 1'b0;
        total++; if (pc_out !== 32'h400 || count !== 3'd1)
            begin bad++; $display("FAIL midrst_head got pc=%h cnt=%0d exp 400/1", pc_out, count); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] next_pc = 32'h1000;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            pc_in     = next_pc;
            instr_in  = $urandom;
            if (in_valid && in_ready && !flush) next_pc = next_pc + 32'd4;
            tick();
            total++;
            if (count !== 3'(mq.size()) || out_valid !== (mq.size() != 0) || in_ready !== (mq.size() != DEPTH) ||
                pc_out !== (mq.size() != 0 ? mq[0][63:32] : 32'h0) ||
                instr_out !== (mq.size() != 0 ? mq[0][31:0] : NOP)) begin
                bad++;
                $display("FAIL random%0d got cnt=%0d ov=%b ir=%b pc=%h ins=%h exp cnt=%0d", c, count, out_valid, in_ready, pc_out, instr_out, mq.size());
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill_stall();
        test_full_simultaneous();
        test_flush();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_buffer.md
INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of {pc, instr} entries (power of two, 2..16).
REQ-002 SHALL provide parameter NOP_INSTR, default 32'h00000013, instruction driven when empty.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port in_valid  input  1  fetch side presents a valid pc/instr pair.
REQ-006 SHALL provide port pc_in  input  32  PC of fetched instruction.
REQ-007 SHALL provide port instr_in  input  32  fetched instruction word from imem.
REQ-008 SHALL provide port in_ready  output  1  buffer accepts a push this cycle; fetch holds PC when low.
REQ-009 SHALL provide port flush  input  1  branch/jump redirect from EX; discard all entries.
REQ-010 SHALL provide port out_valid  output  1  head entry valid toward IF/ID register.
REQ-011 SHALL provide port pc_out  output  32  PC of head entry.
REQ-012 SHALL provide port instr_out  output  32  instruction of head entry.
REQ-013 SHALL provide port out_ready  input  1  decode side consumes head this cycle (low = decode stall).
REQ-014 SHALL provide port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 Push SHALL occur on a rising edge when in_valid && in_ready && !flush; entry written at write pointer, write pointer +1.
REQ-016 Pop SHALL occur on a rising edge when out_valid && out_ready && !flush; read pointer +1.
REQ-017 in_ready SHALL equal (count != DEPTH), independent of out_ready (no pass-through when full).
REQ-018 out_valid SHALL equal (count != 0).
REQ-019 pc_out/instr_out SHALL show the head entry combinationally from storage while out_valid=1.
REQ-020 While empty, instr_out SHALL be NOP_INSTR and pc_out SHALL be 32'h0.
REQ-021 Latency SHALL be one cycle: an entry pushed at edge N appears on outputs after edge N; no empty-bypass.
REQ-022 Order SHALL be strict FIFO; pc/instr pairs never separated or reordered.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-024 At count==DEPTH, a pop SHALL free one slot; a push in that same cycle SHALL be refused (in_ready=0).
REQ-025 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without extra logic.
REQ-026 count SHALL be maintained as a register: +1 on push-only, -1 on pop-only, unchanged otherwise.
REQ-027 flush SHALL be synchronous and highest priority: next edge sets count=0, both pointers=0, ignores any same-cycle push/pop.
REQ-028 in_valid with in_ready=0 SHALL have no effect; fetch must re-present the pair.
REQ-029 out_ready with out_valid=0 SHALL have no effect; count SHALL never underflow or overflow.

Reset
REQ-030 Asserting rst SHALL immediately (without clock) clear count and both pointers to 0.
REQ-031 During and after reset: out_valid=0, in_ready=1, instr_out=NOP_INSTR, pc_out=0, count=0.
REQ-032 Storage contents SHALL NOT require reset; they are unobservable while empty.
REQ-033 rst asserted mid-operation (any count) SHALL discard all entries; first push after deassertion becomes head.

Verification
REQ-034 Reset: rst=1 at t=5 for 10 ns, no clock edge -> count=0, out_valid=0, in_ready=1, instr_out=32'h00000013, pc_out=0.
REQ-035 Streaming: out_ready=1, push pc 0,4,8 with instrs A,B,C on consecutive edges -> outputs pc 0/A, 4/B, 8/C one cycle after each push, count stays <=1.
REQ-036 Fill/stall: out_ready=0, push 5 pairs -> count=4 after 4 edges, in_ready=0, 5th pair refused; then out_ready=1 -> pops pc 0,4,8,12 in order, 5th accepted only after re-presentation.
REQ-037 Full simultaneous: count=4, in_valid=1, out_ready=1 -> one pop, no push, count=3, in_ready=1 next cycle.
REQ-038 Flush: count=3, flush=1 with in_valid=1 and out_ready=1 on same edge -> count=0, out_valid=0, instr_out=NOP; next push pc 32'h100 appears as head.
REQ-039 Wrap: push/pop 10 pairs with count oscillating 1..3 -> order preserved across pointer wrap, no lost or duplicated entries.
